// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between a buffered write stream and a fixed-latency read stream.
// Optional read-after-write forwarding from the write FIFO: SRAM_ARB_RAW_FWD_EN.
module sram_port_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int WFIFO_DEPTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_wr_valid,
  output logic                              o_wr_ready,
  input  logic [ADDR_W-1:0]                 i_wr_addr,
  input  logic [DATA_W-1:0]                 i_wr_data,
  input  logic                              i_rd_valid,
  input  logic [ADDR_W-1:0]                 i_rd_addr,
  output logic [DATA_W-1:0]                 o_rd_data,
  output logic                              o_rd_data_valid,
  output logic [ADDR_W-1:0]                 o_sram_addr,
  output logic [DATA_W-1:0]                 o_sram_wdata,
  output logic                              o_sram_dq_oe,
  output logic                              o_sram_we_n,
  input  logic [DATA_W-1:0]                 i_sram_rdata,
  output logic [$clog2(WFIFO_DEPTH+1)-1:0]  o_fifo_level
);
  localparam int IW = $clog2(WFIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_mem [WFIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [WFIFO_DEPTH];
  logic [IW:0] wr_ptr, rd_ptr, level;
  logic [IW-1:0] rd_idx;
  logic empty, full, push, pop;
  logic [DATA_W-1:0] rd_src;
  assign level = wr_ptr - rd_ptr;
  assign empty = level == '0;
  assign full = level[IW];
  assign rd_idx = rd_ptr[IW-1:0];
  assign push = i_wr_valid && !full;
  assign o_wr_ready = !full;
  assign o_fifo_level = level;
  // Reads always win; leaving a READ with writes pending costs one turnaround cycle.
  always_comb state_nx = i_rd_valid ? READ : empty ? IDLE : (state == READ) ? TURN : WRITE;
  assign pop = state_nx == WRITE;
  always_ff @(posedge i_clk)
    if (push) begin
      addr_mem[wr_ptr[IW-1:0]] <= i_wr_addr;
      data_mem[wr_ptr[IW-1:0]] <= i_wr_data;
    end
`ifdef SRAM_ARB_RAW_FWD_EN
  logic fwd_hit, fwd_hit_q;
  logic [DATA_W-1:0] fwd_data, fwd_data_q;
  logic [IW-1:0] fwd_idx;
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    fwd_idx = '0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      fwd_idx = rd_idx + IW'(i);
      if (i < int'(level) && addr_mem[fwd_idx] == i_rd_addr) begin
        fwd_hit = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      fwd_hit_q <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q <= i_rd_valid && fwd_hit;
      fwd_data_q <= fwd_data;
    end
  assign rd_src = fwd_hit_q ? fwd_data_q : i_sram_rdata;
`else
  assign rd_src = i_sram_rdata;
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_sram_addr <= '0;
      o_sram_wdata <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_we_n <= 1'b1;
      o_rd_data <= '0;
      o_rd_data_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_sram_addr <= i_rd_valid ? i_rd_addr : pop ? addr_mem[rd_idx] : o_sram_addr;
      o_sram_wdata <= pop ? data_mem[rd_idx] : o_sram_wdata;
      o_sram_dq_oe <= pop;
      o_sram_we_n <= !pop;
      o_rd_data_valid <= state == READ;
      if (state == READ) o_rd_data <= rd_src;
    end
endmodule
